// File: rtl/wave_mem_pkg.sv
// Shared definitions for the waverv memory controller slice.
// Holds the controller state encoding, the I/O register offsets and the
// address bit that splits RAM from memory-mapped I/O.
package wave_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_READ      = 2'd1,
    ST_WRITE     = 2'd2,
    ST_UART_WAIT = 2'd3
  } state_t;

  // I/O register offsets within the I/O region; only address[3:2] is
  // significant, address[1:0] is ignored like everywhere else.
  localparam logic [3:0] LED_OFS   = 4'h0;
  localparam logic [3:0] UART_OFS  = 4'h4;
  localparam logic [3:0] CYCLE_OFS = 4'h8;

  // Address bit that selects the I/O region.
  localparam int IO_SELECT_BIT = 22;

  // Width of the latency down-counter (latencies up to 255 cycles).
  localparam int LAT_W = 8;

endpackage

// File: rtl/wave_byte_ram.sv
// Word-wide RAM with per-byte write enables and a registered read port.
// Ports:
//   clk   - clock, rising edge
//   addr  - word index
//   we    - write strobe, lanes selected by be
//   be    - byte enables, bit n = byte lane n
//   wdata - lane-aligned write data
//   re    - read strobe; rdata captures mem[addr] on this edge
//   rdata - registered read data, held between reads
// Contents are deliberately not reset.
module wave_byte_ram #(
  parameter int ADDR_WORDS = 256,
  parameter int AW         = $clog2(ADDR_WORDS)
) (
  input  logic          clk,
  input  logic [AW-1:0] addr,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [31:0]   wdata,
  input  logic          re,
  output logic [31:0]   rdata
);

  logic [31:0] mem_r [ADDR_WORDS];
  logic [31:0] rdata_r;

  // Byte-masked write and registered read of the storage array.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) begin
          mem_r[addr][i*8 +: 8] <= wdata[i*8 +: 8];
        end
      end
    end
    if (re) begin
      rdata_r <= mem_r[addr];
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/wave_memory_controller.sv
// Memory-side slave for the waverv core load/store port.
// Serves a byte-maskable RAM and a small I/O region (LEDs, UART transmit
// handshake, free-running cycle counter).
// Ports:
//   clk, reset                 - clock and asynchronous active-high reset
//   load, store                - level request strobes from the core
//   memory_access_address      - byte address (bit 22 selects I/O)
//   memory_write_data/_mask    - lane-aligned store data and byte enables
//   memory_read_data           - load result, held until the next load ends
//   memory_read_busy/_write_busy - handshakes back to the core
//   io_leds                    - LED register
//   io_uart_tx_data/_valid     - UART transmit byte and its valid flag
//   io_uart_tx_ready           - UART accepts the byte
module wave_memory_controller
  import wave_mem_pkg::*;
#(
  parameter int          ADDR_WORDS    = 256,
  parameter int          READ_LATENCY  = 2,
  parameter int          WRITE_LATENCY = 1,
  parameter logic [31:0] IO_BASE       = 32'h0040_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        store,
  input  logic [31:0] memory_access_address,
  input  logic [31:0] memory_write_data,
  input  logic [3:0]  memory_write_mask,
  output logic [31:0] memory_read_data,
  output logic        memory_read_busy,
  output logic        memory_write_busy,
  output logic [7:0]  io_leds,
  output logic [7:0]  io_uart_tx_data,
  output logic        io_uart_tx_valid,
  input  logic        io_uart_tx_ready
);

  localparam int AW = $clog2(ADDR_WORDS);
  // Cycles spent in READ/WRITE after the request cycle.
  localparam logic [LAT_W-1:0] RD_WAIT = LAT_W'(READ_LATENCY - 1);
  localparam logic [LAT_W-1:0] WR_WAIT = LAT_W'(WRITE_LATENCY - 1);
  localparam logic RD_ONE_CYCLE = (READ_LATENCY == 1);
  localparam logic WR_ONE_CYCLE = (WRITE_LATENCY == 1);

  state_t           state_r;
  logic [LAT_W-1:0] lat_cnt_r;
  logic [31:0]      addr_r;
  logic [31:0]      wdata_r;
  logic [3:0]       mask_r;
  logic [7:0]       leds_r;
  logic [7:0]       tx_data_r;
  logic             tx_valid_r;
  logic [31:0]      cycle_r;
  logic [31:0]      io_rdata_r;
  logic             sel_ram_r;

  logic [31:0] req_addr_s;
  logic [31:0] req_wdata_s;
  logic [3:0]  req_mask_s;
  logic        io_sel_s;
  logic [3:0]  ofs_s;
  logic        accept_s;
  logic        st_acc_s;
  logic        ld_acc_s;
  logic        uart_st_s;
  logic        wr_done_s;
  logic        rd_done_s;
  logic [31:0] io_rvalue_s;
  logic [31:0] ram_rdata_s;
  logic        unused_s;

  // In IDLE the live request is used so one-cycle accesses can complete at
  // the accepting edge; afterwards the latched copy is used.
  always_comb begin
    req_addr_s  = addr_r;
    req_wdata_s = wdata_r;
    req_mask_s  = mask_r;
    if (state_r == ST_IDLE) begin
      req_addr_s  = memory_access_address;
      req_wdata_s = memory_write_data;
      req_mask_s  = memory_write_mask;
    end else begin
      req_addr_s  = addr_r;
      req_wdata_s = wdata_r;
      req_mask_s  = mask_r;
    end
  end

  assign io_sel_s  = (req_addr_s[IO_SELECT_BIT] == IO_BASE[IO_SELECT_BIT]);
  assign ofs_s     = {req_addr_s[3:2], 2'b00};

  assign accept_s  = (state_r == ST_IDLE) && !reset;
  assign st_acc_s  = accept_s && store;
  assign ld_acc_s  = accept_s && load && !store;
  assign uart_st_s = st_acc_s && io_sel_s && (ofs_s == UART_OFS);

  // Completion strobes: the edge at which the access takes effect.
  assign wr_done_s = (st_acc_s && !uart_st_s && WR_ONE_CYCLE) ||
                     ((state_r == ST_WRITE) && (lat_cnt_r == LAT_W'(1)) && !reset);
  assign rd_done_s = (ld_acc_s && RD_ONE_CYCLE) ||
                     ((state_r == ST_READ) && (lat_cnt_r == LAT_W'(1)) && !reset);

  // Busy handshakes are combinational so the request cycle already reports busy.
  assign memory_read_busy  = !reset && ((state_r == ST_READ) ||
                             ((state_r == ST_IDLE) && load && !store));
  assign memory_write_busy = !reset && ((state_r == ST_WRITE) ||
                             (state_r == ST_UART_WAIT) ||
                             ((state_r == ST_IDLE) && store));

  // Value returned by an I/O load, sampled at its completion edge.
  always_comb begin
    io_rvalue_s = 32'h0000_0000;
    case (ofs_s)
      LED_OFS:   io_rvalue_s = {24'h00_0000, leds_r};
      UART_OFS:  io_rvalue_s = {31'h0000_0000, io_uart_tx_ready};
      CYCLE_OFS: io_rvalue_s = cycle_r;
      default:   io_rvalue_s = 32'h0000_0000;
    endcase
  end

  wave_byte_ram #(
    .ADDR_WORDS (ADDR_WORDS),
    .AW         (AW)
  ) u_ram (
    .clk   (clk),
    .addr  (req_addr_s[AW+1:2]),
    .we    (wr_done_s && !io_sel_s),
    .be    (req_mask_s),
    .wdata (req_wdata_s),
    .re    (rd_done_s && !io_sel_s),
    .rdata (ram_rdata_s)
  );

  // Control FSM, I/O registers, cycle counter and load result capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      lat_cnt_r  <= '0;
      addr_r     <= 32'h0000_0000;
      wdata_r    <= 32'h0000_0000;
      mask_r     <= 4'b0000;
      leds_r     <= 8'h00;
      tx_data_r  <= 8'h00;
      tx_valid_r <= 1'b0;
      cycle_r    <= 32'h0000_0000;
      io_rdata_r <= 32'h0000_0000;
      sel_ram_r  <= 1'b0;
    end else begin
      cycle_r <= cycle_r + 32'd1;
      case (state_r)
        ST_IDLE: begin
          if (store) begin
            addr_r  <= memory_access_address;
            wdata_r <= memory_write_data;
            mask_r  <= memory_write_mask;
            if (uart_st_s) begin
              tx_data_r  <= memory_write_data[7:0];
              tx_valid_r <= 1'b1;
              state_r    <= ST_UART_WAIT;
            end else if (!WR_ONE_CYCLE) begin
              lat_cnt_r <= WR_WAIT;
              state_r   <= ST_WRITE;
            end
          end else if (load) begin
            addr_r <= memory_access_address;
            if (!RD_ONE_CYCLE) begin
              lat_cnt_r <= RD_WAIT;
              state_r   <= ST_READ;
            end
          end
        end
        ST_READ, ST_WRITE: begin
          if (lat_cnt_r == LAT_W'(1)) begin
            state_r <= ST_IDLE;
          end else begin
            lat_cnt_r <= lat_cnt_r - LAT_W'(1);
          end
        end
        ST_UART_WAIT: begin
          if (io_uart_tx_ready) begin
            tx_valid_r <= 1'b0;
            state_r    <= ST_IDLE;
          end
        end
        default: state_r <= ST_IDLE;
      endcase

      if (wr_done_s && io_sel_s && (ofs_s == LED_OFS) && req_mask_s[0]) begin
        leds_r <= req_wdata_s[7:0];
      end
      if (rd_done_s) begin
        sel_ram_r  <= !io_sel_s;
        io_rdata_r <= io_rvalue_s;
      end
    end
  end

  // Load result is a select between two registers: the RAM read register or
  // the captured I/O value.
  assign memory_read_data = sel_ram_r ? ram_rdata_s : io_rdata_r;
  assign io_leds          = leds_r;
  assign io_uart_tx_data  = tx_data_r;
  assign io_uart_tx_valid = tx_valid_r;

  // Address bits that play no part in decode.
  assign unused_s = ^{req_addr_s[31:IO_SELECT_BIT+1], req_addr_s[IO_SELECT_BIT-1:AW+2],
                      req_addr_s[1:0]};

endmodule

// File: doc/wave_memory_controller.md
Name: wave_memory_controller

Overview:
- Memory-side slave for the waverv core's load/store port.
- Accepts load/store requests, drives busy handshakes back to the core, and serves a word-wide byte-maskable RAM plus a small memory-mapped I/O region (LED register, UART transmit handshake, free-running cycle counter).
- Sits directly downstream of the core on its memory_access_address / memory_read_data bus.

Parameters:
- ADDR_WORDS, 256: RAM depth in 32-bit words; power of two.
- READ_LATENCY, 2: cycles memory_read_busy stays high per load; must be ≥1.
- WRITE_LATENCY, 1: cycles memory_write_busy stays high per RAM/LED store; must be ≥1.
- IO_BASE, 32'h0040_0000: I/O region base. Address bit 22 set selects I/O.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- load  in  1  load request strobe from core
- store  in  1  store request strobe from core
- memory_access_address  in  32  byte address
- memory_write_data  in  32  store data, already lane-aligned by core
- memory_write_mask  in  4  byte enables, bit n = byte lane n
- memory_read_data  out  32  load result
- memory_read_busy  out  1  load in progress
- memory_write_busy  out  1  store in progress
- io_leds  out  8  LED register
- io_uart_tx_data  out  8  UART transmit byte
- io_uart_tx_valid  out  1  UART byte valid
- io_uart_tx_ready  in  1  UART accepts byte

Behaviour:
- Reset values: state IDLE; memory_read_data=0; both busy signals=0; io_leds=0; io_uart_tx_data=0; io_uart_tx_valid=0; cycle counter=0.
- RAM contents are not cleared by reset.
- Clock and reset: one clock domain, asynchronous active-high reset (clk, reset).
- States: IDLE, READ, WRITE, UART_WAIT.
- Busy outputs (combinational):
  - memory_read_busy = (state==READ) | (state==IDLE & load & !store).
  - memory_write_busy = (state==WRITE|UART_WAIT) | (state==IDLE & store).
- Address decode:
  - Word index = address[log2(ADDR_WORDS)+1:2].
  - Out-of-range RAM addresses wrap modulo ADDR_WORDS.
  - address[1:0] ignored.
  - I/O offsets (address[3:0]): 0x0 LED, 0x4 UART, 0x8 cycle counter.
- Load:
  - Sampled in IDLE at edge E0 → READ with counter loaded.
  - memory_read_busy is high for exactly READ_LATENCY cycles, starting with the request cycle.
  - memory_read_data updates at the edge that returns to IDLE. It is valid the cycle busy falls and is held until the next load completes.
  - I/O reads:
    - 0x0 → {24'b0, io_leds}.
    - 0x4 → {31'b0, io_uart_tx_ready}, sampled at completion.
    - 0x8 → counter value at completion.
    - Unmapped → 0.
- Store, RAM or LED target:
  - Sampled in IDLE → WRITE.
  - memory_write_busy is high for exactly WRITE_LATENCY cycles.
  - Masked bytes are written at the final edge.
  - Mask 4'b0000 writes nothing but still takes the full latency.
  - LED store writes write_data[7:0] only if mask[0].
- Store, UART target (0x4):
  - Sampled in IDLE → UART_WAIT.
  - io_uart_tx_data=write_data[7:0]; io_uart_tx_valid=1.
  - Returns to IDLE and clears valid at the first edge where io_uart_tx_ready=1.
  - memory_write_busy stays high until that edge; no timeout.
  - Unmapped I/O stores complete with WRITE_LATENCY and have no effect.
- Simultaneous load and store in IDLE: store wins; load is not accepted and must be held by the core.
- Requests arriving while not IDLE are ignored.
- Cycle counter: 32-bit, increments every cycle, wraps 0xFFFF_FFFF→0.
- Reset mid-operation: returns to IDLE immediately. The pending write is discarded and the RAM is untouched by that write.
- Request strobes are level-sampled; the core must drop them once it sees busy fall.

Decomposition:
- Package wave_mem_pkg: state encoding, I/O offset constants (LED_OFS, UART_OFS, CYCLE_OFS), IO_SELECT_BIT=22.
- Sub-module wave_byte_ram: ADDR_WORDS×32 RAM with 4 byte-enables and registered read, used by the controller for the RAM region.

Test Plan:
- Reset then load 0x00000010 after preloading word 4=0xDEADBEEF → read_busy high 2 cycles, then data 0xDEADBEEF with busy low.
- Store 0x11223344 mask 4'b0100 to word 4 (=0xDEADBEEF), then load → 0xDE22BEEF; mask 4'b0000 leaves value unchanged and write_busy is still high 1 cycle.
- UART store 0x41 at 0x00400004 with tx_ready low 5 cycles → tx_valid=1, tx_data=0x41, write_busy high 6 cycles, both drop the edge after ready rises.
- load=store=1 to the LED register 0x00400000 with data 0xA5 → LEDs=0xA5, read_busy stays 0, later LED read returns 0x000000A5.
- Address 0x00000400 with ADDR_WORDS=256 aliases word 0; a read of 0x0040000C returns 0.
- Assert reset during UART_WAIT → busy and tx_valid drop asynchronously, io_leds=0, counter restarts at 0.
